// File: rtl/uart_msg_transmitter.sv
// rtl/uart_msg_transmitter.sv - FIFO-buffered multi-byte UART transmitter, MSB byte first, 8N1
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7 of every byte.
module uart_msg_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MSG_WIDTH    = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 isNew,
    input  logic [MSG_WIDTH-1:0] message,
    output logic                 serialOut,
    output logic                 ready,
    output logic                 busy,
    output logic                 overflow
);
    localparam int NB = (MSG_WIDTH + 7) / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [MSG_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_idx;
    logic [BW-1:0]        byte_idx;
    logic [MSG_WIDTH-1:0] shift_word;
    logic [NB*8-1:0]      padded;
    logic [7:0]           cur_byte;
    logic                 baud_end;
    logic                 last_byte;
    logic                 line_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = isNew && !full;
    assign ready = !full;
    assign busy  = (state != S_IDLE) || !empty;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == BYTE_LAST);
    assign pop = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_end && last_byte));

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= message;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (isNew && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Zero-extend the word and pick byte_idx counting from the most significant byte.
    always_comb begin
        padded                  = '0;
        padded[MSG_WIDTH-1:0]   = shift_word;
        cur_byte                = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (BW'(k) == byte_idx) begin
                cur_byte = padded[(NB-1-k)*8 +: 8];
            end
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = cur_byte[bit_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_next = ^cur_byte;
`endif
            default:  line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift_word <= '0;
            serialOut  <= 1'b1;
        end else begin
            serialOut <= line_next;
            if (state != S_IDLE) begin
                baud_cnt <= baud_end ? '0 : baud_cnt + CW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift_word <= mem[rd_ptr[AW-1:0]];
                        byte_idx   <= '0;
                        baud_cnt   <= '0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        if (!last_byte) begin
                            byte_idx <= byte_idx + BW'(1);
                            state    <= S_START;
                        end else if (pop) begin
                            shift_word <= mem[rd_ptr[AW-1:0]];
                            byte_idx   <= '0;
                            state      <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_msg_transmitter.sv
// tb/tb_uart_msg_transmitter.sv - self-checking bench for uart_msg_transmitter
module tb_uart_msg_transmitter;
    localparam int CPB   = 4;
    localparam int MW    = 20;
    localparam int DEPTH = 4;
    localparam int NB    = (MW + 7) / 8;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int MSG_CYC = NB * FB * CPB;

    logic          clock = 1'b0;
    logic          reset;
    logic          isNew;
    logic [MW-1:0] message;
    logic          serialOut;
    logic          ready;
    logic          busy;
    logic          overflow;

    uart_msg_transmitter #(.CLKS_PER_BIT(CPB), .MSG_WIDTH(MW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .isNew(isNew), .message(message),
        .serialOut(serialOut), .ready(ready), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] rx_q[$];
    logic       rx_par[$];
    int         rx_t[$];
    int         frame_err = 0;
    int         par_err   = 0;

    // Line decoder: samples each bit in its middle, independent of the DUT internals.
    initial begin : decoder
        logic [7:0] d;
        logic       p;
        bit         ab;
        bit         stop_bad;
        int         t0;
        forever begin
            @(negedge clock);
            if (!reset && serialOut === 1'b0) begin
                t0 = cyc; ab = 0; stop_bad = 0; d = 8'h00; p = 1'b0;
                for (int j = 0; j < FB; j++) begin
                    repeat ((j == 0) ? CPB/2 : CPB) begin
                        @(negedge clock);
                        if (reset) ab = 1;
                    end
                    if (j == 0) begin
                        if (serialOut !== 1'b0) ab = 1;
                    end else if (j <= 8) d[j-1] = serialOut;
                    else if (j == 9 && FB == 11) p = serialOut;
                    else if (serialOut !== 1'b1) stop_bad = 1;
                end
                if (!ab) begin
                    if (stop_bad) frame_err++;
                    if (FB == 11 && p != ^d) par_err++;
                    rx_q.push_back(d); rx_par.push_back(p); rx_t.push_back(t0);
                end
            end
        end
    end

    // Transaction-level reference: FIFO occupancy and message end times.
    int            m_count = 0;
    int            m_end   = 0;
    int            edge_n  = 0;
    bit            m_act   = 0;
    bit            m_ov    = 0;
    logic [MW-1:0] exp_w[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [MW-1:0] w, input int k);
        logic [NB*8-1:0] z;
        z = '0;
        z[MW-1:0] = w;
        z = z >> (8 * (NB - 1 - k));
        return z[7:0];
    endfunction

    function automatic logic wave(input logic [MW-1:0] w, input int i);
        int k;
        int b;
        logic [7:0] d;
        k = i / (FB * CPB);
        b = (i / CPB) % FB;
        d = byte_of(w, k);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (FB == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic step(input logic v, input logic [MW-1:0] m);
        bit full_m;
        isNew = v; message = m;
        full_m = (m_count == DEPTH);
        edge_n++;
        if (m_count > 0 && (!m_act || edge_n == m_end)) begin
            m_count--; m_act = 1; m_end = edge_n + MSG_CYC;
        end else if (m_act && edge_n == m_end) begin
            m_act = 0;
        end
        if (v) begin
            if (full_m) m_ov = 1;
            else begin m_count++; exp_w.push_back(m); end
        end
        @(posedge clock);
        #1;
        isNew = 1'b0;
    endtask

    task automatic clear_q();
        exp_w.delete(); rx_q.delete(); rx_par.delete(); rx_t.delete();
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        #2;
        m_count = 0; m_act = 0; m_ov = 0;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        clear_q();
    endtask

    task automatic check_stream(input string name);
        logic [7:0] eb[$];
        int mism;
        mism = 0;
        foreach (exp_w[i]) for (int k = 0; k < NB; k++) eb.push_back(byte_of(exp_w[i], k));
        check({name, "_len"}, rx_q.size(), eb.size());
        for (int i = 0; i < eb.size() && i < rx_q.size(); i++) if (rx_q[i] != eb[i]) mism++;
        check({name, "_bytes"}, mism, 0);
    endtask

    task automatic single_word(input logic [MW-1:0] w, input string name);
        int mism;
        clear_q();
        step(1'b1, w);
        step(1'b0, '0);
        check({name, "_line_pre"}, serialOut, 1);
        mism = 0;
        for (int i = 0; i < MSG_CYC; i++) begin
            step(1'b0, '0);
            if (serialOut !== wave(w, i)) mism++;
            if (i == MSG_CYC - 2) check({name, "_busy_last"}, busy, 1);
            if (i == MSG_CYC - 1) check({name, "_busy_end"}, busy, 0);
        end
        check({name, "_wave"}, mism, 0);
        repeat (4) step(1'b0, '0);
        check_stream(name);
    endtask

    typedef struct {
        logic          v;
        logic [MW-1:0] m;
        logic          e_ready;
        logic          e_busy;
        logic          e_ov;
        logic          e_line;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int gaps;
        int pop_e;
        int tgt;
        int r_err;
        int b_err;
        int o_err;
        int pct;

        vecs[0] = '{1'b1, 20'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 20'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 20'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 20'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 20'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 20'd6, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 20'd0, 1'b0, 1'b1, 1'b1, 1'b0};

        isNew = 1'b0; message = '0;
        hit_reset();
        check("rst_line", serialOut, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        release_reset();

        // FIFO fill with back-to-back strobes
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].v, vecs[i].m);
            check($sformatf("fill%0d_ready", i), ready, vecs[i].e_ready);
            check($sformatf("fill%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("fill%0d_ovf", i), overflow, vecs[i].e_ov);
            check($sformatf("fill%0d_line", i), serialOut, vecs[i].e_line);
        end
        repeat (5 * MSG_CYC + 10) step(1'b0, '0);
        check_stream("fill");
        check("fill_nbytes", rx_q.size(), 5 * NB);
        if (rx_q.size() == 5 * NB) check("fill_lastbyte", rx_q[5*NB-1], 8'h05);
        gaps = 0;
        for (int i = 0; i + 1 < rx_t.size(); i++) if (rx_t[i+1] - rx_t[i] != FB * CPB) gaps++;
        check("fill_no_gap", gaps, 0);
        check("fill_busy_done", busy, 0);
        check("fill_ovf_sticky", overflow, 1);

        // Reset during data bit 3 of the second byte
        clear_q();
        step(1'b1, 20'hA5C3F);
        step(1'b1, 20'h11111);
        step(1'b1, 20'h22222);
        tgt = FB * CPB + 4 * CPB + 1;
        repeat (tgt) step(1'b0, '0);
        check("mid_line_before", serialOut, wave(20'hA5C3F, tgt));
        hit_reset();
        check("mid_rst_line", serialOut, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_ovf", overflow, 0);
        release_reset();
        repeat (FB * CPB + 10) step(1'b0, '0);
        check("mid_discard_busy", busy, 0);
        check("mid_discard_rx", rx_q.size(), 0);

        single_word(20'h00001, "bit");
        single_word(20'hA5C3F, "single");
`ifdef UART_TX_PARITY_EN
        single_word(20'h00007, "par");
        if (rx_par.size() == 3) begin
            check("par_byte0", rx_par[0], 0);
            check("par_byte2", rx_par[2], 1);
        end else check("par_count", rx_par.size(), 3);
`endif

        // Strobe on the exact pop edge while full
        hit_reset();
        release_reset();
        step(1'b1, 20'h10A01);
        pop_e = edge_n + 1 + MSG_CYC;
        step(1'b1, 20'h20B02);
        step(1'b1, 20'h30C03);
        step(1'b1, 20'h40D04);
        step(1'b1, 20'h50E05);
        while (edge_n < pop_e - 1) step(1'b0, '0);
        check("sim_pre_ready", ready, 0);
        check("sim_pre_ovf", overflow, 0);
        step(1'b1, 20'h60F06);
        check("sim_drop_ovf", overflow, 1);
        check("sim_post_ready", ready, 1);
        step(1'b1, 20'h70A77);
        check("sim_late_ready", ready, 0);
        repeat (5 * MSG_CYC + 10) step(1'b0, '0);
        check_stream("sim");
        check("sim_nbytes", rx_q.size(), 6 * NB);
        if (rx_q.size() == 6 * NB) check("sim_lastbyte", rx_q[6*NB-1], 8'h77);

        // Randomised bursts against the reference
        hit_reset();
        release_reset();
        r_err = 0; b_err = 0; o_err = 0;
        for (int i = 0; i < 2500; i++) begin
            pct = ((i / 300) % 2 == 1) ? 60 : 2;
            step(($urandom_range(0, 99) < pct), MW'($urandom));
            if (ready !== (m_count < DEPTH)) r_err++;
            if (busy !== (m_act || m_count > 0)) b_err++;
            if (overflow !== m_ov) o_err++;
        end
        check("rand_ready", r_err, 0);
        check("rand_busy", b_err, 0);
        check("rand_ovf", o_err, 0);
        repeat ((DEPTH + 1) * MSG_CYC + 10) step(1'b0, '0);
        check_stream("rand");

        check("frame_err", frame_err, 0);
`ifdef UART_TX_PARITY_EN
        check("parity_err", par_err, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
